// File: rtl/hilo_result_unit.sv
// hilo_result_unit: HI/LO result bank capturing one in-flight long-latency op, with MTHI/MTLO, busy stall and sticky error.
module hilo_result_unit #(
  parameter int DATA_W  = 32,
  parameter int N_SRC   = 2,
  parameter int SRC_W   = N_SRC > 1 ? $clog2(N_SRC) : 1,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SRC_W-1:0]        start_src,
  input  logic [N_SRC-1:0]        src_done,
  input  logic [N_SRC*DATA_W-1:0] src_hi,
  input  logic [N_SRC*DATA_W-1:0] src_lo,
  input  logic [N_SRC-1:0]        src_err,
  input  logic                    mthi_we,
  input  logic                    mtlo_we,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       hi_out,
  output logic [DATA_W-1:0]       lo_out,
  output logic                    busy,
  output logic                    err,
  output logic [SRC_W-1:0]        last_src
);
  localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SRC_W-1:0]  pend_q, pend_d, last_q, last_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_a [N_SRC];
  logic [DATA_W-1:0] lo_a [N_SRC];
  logic              src_ok, done_p, to_hit;

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign hi_a[i] = src_hi[i*DATA_W +: DATA_W];
    assign lo_a[i] = src_lo[i*DATA_W +: DATA_W];
  end

  assign src_ok = {1'b0, start_src} < (SRC_W+1)'(N_SRC);
  assign done_p = src_done[pend_q];
  // Counter holds TIMEOUT-1 on the last allowed BUSY cycle; abort lands on edge entry+TIMEOUT.
  assign to_hit = TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    last_d  = last_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      hi_d = mthi_we ? wdata : hi_q;
      lo_d = mtlo_we ? wdata : lo_q;
      if (start && src_ok) begin
        state_d = BUSY;
        pend_d  = start_src;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q == '1 ? cnt_q : cnt_q + CNT_W'(1);
      if (done_p) begin
        hi_d    = hi_a[pend_q];
        lo_d    = lo_a[pend_q];
        err_d   = src_err[pend_q];
        last_d  = pend_q;
        state_d = IDLE;
      end else if (to_hit) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      last_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = state_q == BUSY;
  assign err      = err_q;
  assign last_src = last_q;
endmodule

// File: tb/tb_hilo_result_unit.sv
// tb_hilo_result_unit: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_hilo_result_unit;
  localparam int DW = 32;
  localparam int NS = 2;
  localparam int SW = 1;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset, start, mthi_we, mtlo_we, busy, err;
  logic [SW-1:0] start_src, last_src;
  logic [NS-1:0] src_done, src_err;
  logic [NS*DW-1:0] src_hi, src_lo;
  logic [DW-1:0] wdata, hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_hi, m_lo;
  logic m_busy, m_err;
  int m_pend, m_last, m_age;

  hilo_result_unit #(.DATA_W(DW), .N_SRC(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .start_src(start_src),
    .src_done(src_done), .src_hi(src_hi), .src_lo(src_lo), .src_err(src_err),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .err(err), .last_src(last_src)
  );

  always #5 clk = ~clk;

  task automatic idle_in();
    reset = 0; start = 0; start_src = '0; src_done = '0; src_err = '0;
    src_hi = '0; src_lo = '0; mthi_we = 0; mtlo_we = 0; wdata = '0;
  endtask

  task automatic put(int i, logic [DW-1:0] h, logic [DW-1:0] l);
    src_hi[i*DW +: DW] = h;
    src_lo[i*DW +: DW] = l;
  endtask

  // Operation-level view: one pending op with an age in cycles; completion or age==TIMEOUT ends it.
  task automatic model();
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_err = 0; m_last = 0; m_age = 0; m_pend = 0;
    end else if (!m_busy) begin
      if (mthi_we) m_hi = wdata;
      if (mtlo_we) m_lo = wdata;
      if (start && int'(start_src) < NS) begin
        m_busy = 1; m_pend = int'(start_src); m_err = 0; m_age = 0;
      end
    end else begin
      m_age++;
      if (src_done[m_pend]) begin
        m_hi = src_hi[m_pend*DW +: DW];
        m_lo = src_lo[m_pend*DW +: DW];
        m_err = src_err[m_pend];
        m_last = m_pend;
        m_busy = 0;
      end else if (m_age == TO) begin
        m_busy = 0; m_err = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic test_reset();
    idle_in(); reset = 1; step(); reset = 0;
    checks++;
    if ({hi_out, lo_out, busy, err, last_src} !== '0) begin
      errors++; $display("FAIL reset_state got %h/%h b%b e%b s%h want all zero", hi_out, lo_out, busy, err, last_src);
    end
    for (int k = 0; k < 5; k++) begin
      src_done = (k % 2 == 0) ? 2'b11 : 2'b00;
      put(0, $urandom, $urandom); put(1, $urandom, $urandom); src_err = 2'b11;
      step();
      checks++;
      if ({hi_out, lo_out, busy, err, last_src} !== '0) begin
        errors++; $display("FAIL idle_stray_done got %h/%h b%b e%b s%h want all zero", hi_out, lo_out, busy, err, last_src);
      end
    end
    idle_in();
  endtask

  task automatic test_mult();
    start = 1; start_src = 0; step(); idle_in();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy got %b want 1", busy); end
    step(); step();
    put(0, 32'h1, 32'hFFFF_FFFE); src_done = 2'b01; step(); idle_in();
    checks++;
    if ({hi_out, lo_out, busy, err, last_src} !== {32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mult_result got %h/%h b%b e%b s%h want 00000001/fffffffe b0 e0 s0", hi_out, lo_out, busy, err, last_src);
    end
  endtask

  task automatic test_divider();
    start = 1; start_src = 1; step(); idle_in();
    put(0, 32'h0, 32'hDEAD_BEEF); src_done = 2'b01; step(); idle_in();
    checks++;
    if ({busy, lo_out} !== {1'b1, 32'hFFFF_FFFE}) begin
      errors++; $display("FAIL div_wrong_unit got b%b lo %h want b1 lo fffffffe", busy, lo_out);
    end
    mtlo_we = 1; wdata = 32'h1234; step(); idle_in();
    checks++;
    if (lo_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mt_in_busy got %h want fffffffe", lo_out); end
    put(1, 32'h55, 32'h7); src_done = 2'b10; src_err = 2'b10; step(); idle_in();
    checks++;
    if ({hi_out, lo_out, busy, err, last_src} !== {32'h55, 32'h7, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL div_result got %h/%h b%b e%b s%h want 00000055/00000007 b0 e1 s1", hi_out, lo_out, busy, err, last_src);
    end
    mthi_we = 1; mtlo_we = 1; wdata = 32'hAAAA_5555; step(); idle_in();
    checks++;
    if ({hi_out, lo_out, err, last_src} !== {32'hAAAA_5555, 32'hAAAA_5555, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mt_both got %h/%h e%b s%h want aaaa5555/aaaa5555 e1 s1", hi_out, lo_out, err, last_src);
    end
  endtask

  task automatic test_timeout();
    start = 1; start_src = 0; step(); idle_in();
    for (int k = 1; k < TO; k++) begin
      step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early cycle %0d got busy %b want 1", k, busy); end
    end
    step();
    checks++;
    if ({hi_out, lo_out, busy, err, last_src} !== {32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL timeout_abort got %h/%h b%b e%b s%h want aaaa5555/aaaa5555 b0 e1 s1", hi_out, lo_out, busy, err, last_src);
    end
    start = 1; start_src = 0; step(); idle_in();
    for (int k = 1; k < TO; k++) step();
    put(0, 32'h11, 32'h22); src_done = 2'b01; src_err = 2'b00; step(); idle_in();
    checks++;
    if ({hi_out, lo_out, busy, err, last_src} !== {32'h11, 32'h22, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_done_wins got %h/%h b%b e%b s%h want 00000011/00000022 b0 e0 s0", hi_out, lo_out, busy, err, last_src);
    end
  endtask

  task automatic test_back_to_back();
    start = 1; start_src = 1; step(); idle_in();
    put(1, 32'h3, 32'h4); src_done = 2'b10; step(); idle_in();
    start = 1; start_src = 0; step(); idle_in();
    checks++;
    if ({busy, hi_out, lo_out, last_src} !== {1'b1, 32'h3, 32'h4, 1'b1}) begin
      errors++; $display("FAIL b2b_accept got b%b %h/%h s%h want b1 00000003/00000004 s1", busy, hi_out, lo_out, last_src);
    end
    put(0, 32'h5, 32'h6); src_done = 2'b01; step(); idle_in();
    checks++;
    if ({busy, hi_out, lo_out, last_src} !== {1'b0, 32'h5, 32'h6, 1'b0}) begin
      errors++; $display("FAIL b2b_second got b%b %h/%h s%h want b0 00000005/00000006 s0", busy, hi_out, lo_out, last_src);
    end
  endtask

  task automatic test_reset_mid_busy();
    start = 1; start_src = 1; step(); idle_in();
    step();
    reset = 1; step(); reset = 0;
    checks++;
    if ({hi_out, lo_out, busy, err, last_src} !== '0) begin
      errors++; $display("FAIL reset_mid got %h/%h b%b e%b s%h want all zero", hi_out, lo_out, busy, err, last_src);
    end
    put(1, 32'h99, 32'h88); src_done = 2'b10; src_err = 2'b10; step(); idle_in();
    checks++;
    if ({hi_out, lo_out, busy, err} !== '0) begin
      errors++; $display("FAIL reset_late_done got %h/%h b%b e%b want all zero", hi_out, lo_out, busy, err);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      start_src = SW'($urandom_range(0, NS - 1));
      src_done = NS'($urandom_range(0, 2) == 0 ? $urandom : 0);
      src_err = NS'($urandom);
      src_hi = {$urandom, $urandom};
      src_lo = {$urandom, $urandom};
      mthi_we = ($urandom_range(0, 4) == 0);
      mtlo_we = ($urandom_range(0, 4) == 0);
      wdata = $urandom;
      step();
      checks++;
      if ({hi_out, lo_out, busy, err, last_src} !== {m_hi, m_lo, m_busy, m_err, SW'(m_last)}) begin
        errors++;
        $display("FAIL random_cycle%0d got %h/%h b%b e%b s%h want %h/%h b%b e%b s%h",
                 k, hi_out, lo_out, busy, err, last_src, m_hi, m_lo, m_busy, m_err, SW'(m_last));
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_mult();
    test_divider();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
